emu_bus_master: RTL and testbench
=================================

Name: emu_bus_master

Overview:
- Clocked bus initiator that drives the emulated peripheral bus (saddress/srd/swr/data) from the host side.
- Accepts a job (two 24-bit arguments) on a valid/ready request port, then runs a fixed access sequence: write A1, write A2, write CTRL (start), poll CTRL status, read W, read L.
- Returns result, ones count and status on a valid/ready response port.
- Sits between the test harness/CPU model and the peripheral; it is the only driver of the bus strobes.

Parameters:
- ADDR_A1, 16'h037F, first argument register address
- ADDR_A2, 16'h0388, second argument register address
- ADDR_CTRL, 16'h03A0, control (write = start) / status (read) address
- ADDR_W, 16'h0390, result register address
- ADDR_L, 16'h0398, ones-count register address
- STROBE_CYCLES, 2, cycles srd/swr held high per access (>=1)
- POLL_GAP, 4, idle cycles between consecutive status polls
- POLL_LIMIT, 1024, maximum status reads before timeout
- BUSY_CODE, 2'b11, status value meaning "still running"

Ports:
- clk  in  1  clock
- n_reset  in  1  reset; asynchronous, active-low
- req_valid  in  1  job request valid
- req_ready  out  1  high only in IDLE
- req_a1  in  24  first argument
- req_a2  in  24  second argument
- rsp_valid  out  1  response valid, held until accepted
- rsp_ready  in  1  response consumer ready
- rsp_w  out  32  result word read from ADDR_W
- rsp_l  out  24  ones count, bits [23:0] of ADDR_L read
- rsp_status  out  2  last status read from ADDR_CTRL
- rsp_timeout  out  1  poll limit exhausted
- busy  out  1  high in any state other than IDLE
- saddress  out  16  bus address
- srd  out  1  read strobe
- swr  out  1  write strobe
- sdata_wr  out  32  write data to peripheral
- sdata_rd  in  32  read data from peripheral

Behaviour:
- Reset (async, immediate): srd=swr=0, saddress=0, sdata_wr=0, rsp_*=0, rsp_valid=0, busy=0, req_ready=1, state IDLE, poll counter 0. Reset mid-access drops strobes combinationally from reset; no partial access is resumed.
- Access timing, identical for every read/write:
  - SETUP: 1 cycle; saddress/sdata_wr driven, strobes 0.
  - STROBE: STROBE_CYCLES cycles; swr or srd = 1.
  - HOLD: 1 cycle; strobes 0, address/data still held.
  - Access length = STROBE_CYCLES+2 cycles.
  - srd and swr are never high together; address is stable from SETUP through HOLD.
- Read sampling: sdata_rd is captured on the clk edge that ends the last STROBE cycle.
- FSM: IDLE -> WR_A1 -> WR_A2 -> WR_CTRL -> POLL -> (GAP -> POLL)* -> RD_W -> RD_L -> RESP -> IDLE.
  - IDLE: req_ready=1. On req_valid&&req_ready, latch req_a1/req_a2, clear poll counter, go to WR_A1.
  - WR_A1: write {8'h0,a1} to ADDR_A1.
  - WR_A2: write {8'h0,a2} to ADDR_A2.
  - WR_CTRL: write 32'h1 to ADDR_CTRL.
  - POLL: read ADDR_CTRL; status = sdata_rd[1:0]; increment poll counter.
    - status != BUSY_CODE -> RD_W.
    - status == BUSY_CODE and counter < POLL_LIMIT -> GAP.
    - otherwise -> RESP with rsp_timeout=1, rsp_w=0, rsp_l=0; RD_W and RD_L are skipped.
  - GAP: POLL_GAP cycles with bus idle, then POLL.
  - RD_W: read ADDR_W into rsp_w.
  - RD_L: read ADDR_L; rsp_l = sdata_rd[23:0].
  - RESP: rsp_valid=1; outputs stable until rsp_ready. On rsp_valid&&rsp_ready -> IDLE. rsp_valid&&rsp_ready in the same cycle as a new req_valid: the request is not accepted that cycle (req_ready is still 0).
- Bus is idle (strobes 0, saddress held at its last value) in IDLE, GAP and RESP.
- req_valid while busy is ignored; the request is not latched.
- Poll counter is 11 bits wide, saturates at POLL_LIMIT and never wraps.
- Latency, no-busy case (first poll returns done, STROBE_CYCLES=2): 6 accesses x 4 = 24 cycles after the accept edge; rsp_valid high in cycle 25.

Test Plan:
- Reset, then idle for 10 cycles -> srd=swr=0, req_ready=1, busy=0, rsp_valid=0.
- Req a1=5, a2=3; model returns status 2'b00, W=32'h28, L=2 -> writes seen: 37F<-5, 388<-3, 3A0<-1; reads 3A0, 390, 398; rsp_w=0x28, rsp_l=2, rsp_timeout=0; rsp_valid at cycle 25.
- Model returns 2'b11 for 3 polls, then 2'b01 -> exactly 4 reads of 3A0, each separated by 4 idle cycles; rsp_status=2'b01.
- Model always returns 2'b11 with POLL_LIMIT=3 -> 3 polls, then rsp_timeout=1, rsp_w=0, no access to 390/398.
- Hold rsp_ready=0 for 7 cycles with req_valid=1 -> rsp stable, no bus activity, no second job; accept the response -> IDLE, next job starts.
- Assert n_reset low during the STROBE phase of WR_A2 -> swr falls immediately, all outputs take reset values; a new job after reset runs the full sequence.

Source files
------------

// File: rtl/emu_bus_master_if.sv
// Host request/response handshake and emulated peripheral bus for emu_bus_master.
// master = the bus initiator; slave = the harness/peripheral side.
interface emu_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_a1;
    logic [23:0] req_a2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_w;
    logic [23:0] rsp_l;
    logic [1:0]  rsp_status;
    logic        rsp_timeout;
    logic        busy;
    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_wr;
    logic [31:0] sdata_rd;

    modport master (
        input  req_valid, req_a1, req_a2, rsp_ready, sdata_rd,
        output req_ready, rsp_valid, rsp_w, rsp_l, rsp_status, rsp_timeout,
               busy, saddress, srd, swr, sdata_wr
    );

    modport slave (
        output req_valid, req_a1, req_a2, rsp_ready, sdata_rd,
        input  req_ready, rsp_valid, rsp_w, rsp_l, rsp_status, rsp_timeout,
               busy, saddress, srd, swr, sdata_wr
    );
endinterface

// File: rtl/emu_bus_master.sv
// Bus initiator: takes a two-argument job, runs write/start/poll/read accesses on the
// emulated peripheral bus and returns the result words on a valid/ready response port.
module emu_bus_master #(
    parameter logic [15:0] ADDR_A1       = 16'h037F,
    parameter logic [15:0] ADDR_A2       = 16'h0388,
    parameter logic [15:0] ADDR_CTRL     = 16'h03A0,
    parameter logic [15:0] ADDR_W        = 16'h0390,
    parameter logic [15:0] ADDR_L        = 16'h0398,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned POLL_GAP      = 4,
    parameter int unsigned POLL_LIMIT    = 1024,
    parameter logic [1:0]  BUSY_CODE     = 2'b11
) (
    input logic               clk,
    input logic               n_reset,
    emu_bus_master_if.master  bus
);

    localparam int unsigned CNT_W    = 11;
    localparam int unsigned HOLD_IDX = STROBE_CYCLES + 1;
    localparam int unsigned GAP_LAST = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;
    localparam int unsigned PH_MAX   = (HOLD_IDX > GAP_LAST) ? HOLD_IDX : GAP_LAST;
    localparam int unsigned PH_W     = $clog2(PH_MAX + 1);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_WR_A1   = 4'd1;
    localparam logic [3:0] S_WR_A2   = 4'd2;
    localparam logic [3:0] S_WR_CTRL = 4'd3;
    localparam logic [3:0] S_POLL    = 4'd4;
    localparam logic [3:0] S_GAP     = 4'd5;
    localparam logic [3:0] S_RD_W    = 4'd6;
    localparam logic [3:0] S_RD_L    = 4'd7;
    localparam logic [3:0] S_RESP    = 4'd8;

    logic [3:0]       state_q, state_d;
    logic [PH_W-1:0]  cnt_q, cnt_d;
    logic [23:0]      a1_q, a1_d, a2_q, a2_d;
    logic [CNT_W-1:0] poll_q, poll_d;
    logic [31:0]      rsp_w_q, rsp_w_d;
    logic [23:0]      rsp_l_q, rsp_l_d;
    logic [1:0]       rsp_status_q, rsp_status_d;
    logic             rsp_timeout_q, rsp_timeout_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             req_ready_q, req_ready_d;
    logic             busy_q, busy_d;
    logic [15:0]      saddress_q, saddress_d;
    logic [31:0]      sdata_wr_q, sdata_wr_d;
    logic             srd_q, srd_d, swr_q, swr_d;
    logic             in_strobe;

    // Next state, datapath captures and next (registered) bus/handshake outputs.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        a1_d          = a1_q;
        a2_d          = a2_q;
        poll_d        = poll_q;
        rsp_w_d       = rsp_w_q;
        rsp_l_d       = rsp_l_q;
        rsp_status_d  = rsp_status_q;
        rsp_timeout_d = rsp_timeout_q;
        saddress_d    = saddress_q;
        sdata_wr_d    = sdata_wr_q;
        srd_d         = 1'b0;
        swr_d         = 1'b0;
        in_strobe     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    state_d       = S_WR_A1;
                    cnt_d         = '0;
                    a1_d          = bus.req_a1;
                    a2_d          = bus.req_a2;
                    poll_d        = '0;
                    rsp_w_d       = '0;
                    rsp_l_d       = '0;
                    rsp_status_d  = '0;
                    rsp_timeout_d = 1'b0;
                end
            end
            S_GAP: begin
                if (cnt_q == PH_W'(GAP_LAST)) begin
                    state_d = S_POLL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PH_W'(1);
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: begin
                // Read data is taken on the edge that closes the last strobe cycle.
                if (cnt_q == PH_W'(STROBE_CYCLES)) begin
                    case (state_q)
                        S_POLL: begin
                            rsp_status_d = bus.sdata_rd[1:0];
                            if (poll_q < CNT_W'(POLL_LIMIT)) poll_d = poll_q + CNT_W'(1);
                        end
                        S_RD_W:  rsp_w_d = bus.sdata_rd;
                        S_RD_L:  rsp_l_d = bus.sdata_rd[23:0];
                        default: ;
                    endcase
                end
                if (cnt_q == PH_W'(HOLD_IDX)) begin
                    cnt_d = '0;
                    case (state_q)
                        S_WR_A1:   state_d = S_WR_A2;
                        S_WR_A2:   state_d = S_WR_CTRL;
                        S_WR_CTRL: state_d = S_POLL;
                        S_POLL: begin
                            if (rsp_status_q != BUSY_CODE) begin
                                state_d = S_RD_W;
                            end else if (poll_q < CNT_W'(POLL_LIMIT)) begin
                                state_d = (POLL_GAP == 0) ? S_POLL : S_GAP;
                            end else begin
                                state_d       = S_RESP;
                                rsp_timeout_d = 1'b1;
                                rsp_w_d       = '0;
                                rsp_l_d       = '0;
                            end
                        end
                        S_RD_W:  state_d = S_RD_L;
                        S_RD_L:  state_d = S_RESP;
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    cnt_d = cnt_q + PH_W'(1);
                end
            end
        endcase

        // Bus outputs follow the state/phase being entered; address held while idle.
        in_strobe = (cnt_d != '0) && (cnt_d <= PH_W'(STROBE_CYCLES));
        case (state_d)
            S_WR_A1: begin
                saddress_d = ADDR_A1;
                sdata_wr_d = {8'h00, a1_d};
                swr_d      = in_strobe;
            end
            S_WR_A2: begin
                saddress_d = ADDR_A2;
                sdata_wr_d = {8'h00, a2_d};
                swr_d      = in_strobe;
            end
            S_WR_CTRL: begin
                saddress_d = ADDR_CTRL;
                sdata_wr_d = 32'h0000_0001;
                swr_d      = in_strobe;
            end
            S_POLL: begin
                saddress_d = ADDR_CTRL;
                srd_d      = in_strobe;
            end
            S_RD_W: begin
                saddress_d = ADDR_W;
                srd_d      = in_strobe;
            end
            S_RD_L: begin
                saddress_d = ADDR_L;
                srd_d      = in_strobe;
            end
            default: ;
        endcase

        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            a1_q          <= '0;
            a2_q          <= '0;
            poll_q        <= '0;
            rsp_w_q       <= '0;
            rsp_l_q       <= '0;
            rsp_status_q  <= '0;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            req_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            saddress_q    <= '0;
            sdata_wr_q    <= '0;
            srd_q         <= 1'b0;
            swr_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            a1_q          <= a1_d;
            a2_q          <= a2_d;
            poll_q        <= poll_d;
            rsp_w_q       <= rsp_w_d;
            rsp_l_q       <= rsp_l_d;
            rsp_status_q  <= rsp_status_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_valid_q   <= rsp_valid_d;
            req_ready_q   <= req_ready_d;
            busy_q        <= busy_d;
            saddress_q    <= saddress_d;
            sdata_wr_q    <= sdata_wr_d;
            srd_q         <= srd_d;
            swr_q         <= swr_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.busy        = busy_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_w       = rsp_w_q;
    assign bus.rsp_l       = rsp_l_q;
    assign bus.rsp_status  = rsp_status_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.saddress    = saddress_q;
    assign bus.sdata_wr    = sdata_wr_q;
    assign bus.srd         = srd_q;
    assign bus.swr         = swr_q;

endmodule

// File: tb/tb_emu_bus_master.sv
// Bench for emu_bus_master: directed table, random jobs against an access-list model,
// a poll-timeout instance (POLL_LIMIT=3) and a mid-access reset.
module tb_emu_bus_master;

    localparam int SC  = 2;
    localparam int GAP = 4;
    localparam logic [15:0] A_A1   = 16'h037F;
    localparam logic [15:0] A_A2   = 16'h0388;
    localparam logic [15:0] A_CTRL = 16'h03A0;
    localparam logic [15:0] A_W    = 16'h0390;
    localparam logic [15:0] A_L    = 16'h0398;

    logic clk = 1'b0;
    logic n_reset;
    always #5 clk = ~clk;

    emu_bus_master_if bif0 ();
    emu_bus_master_if bif1 ();

    emu_bus_master #(.STROBE_CYCLES(SC), .POLL_GAP(GAP), .POLL_LIMIT(1024)) u0 (
        .clk(clk), .n_reset(n_reset), .bus(bif0));
    emu_bus_master #(.STROBE_CYCLES(SC), .POLL_GAP(GAP), .POLL_LIMIT(3)) u1 (
        .clk(clk), .n_reset(n_reset), .bus(bif1));

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] data;
        int          cyc;
    } acc_t;

    acc_t log0[$];
    acc_t exp_q[$];

    // Peripheral behaviour for instance 0: status busy for m_busy polls, then m_fin.
    int          m_busy = 0;
    int          polls0 = 0;
    logic [1:0]  m_fin  = 2'b00;
    logic [31:0] m_w    = '0;
    logic [31:0] m_l    = '0;
    logic [31:0] m_junk = '0;

    assign bif0.sdata_rd = (bif0.saddress == A_CTRL) ? {m_junk[31:2], (polls0 < m_busy) ? 2'b11 : m_fin} :
                           (bif0.saddress == A_W)    ? m_w :
                           (bif0.saddress == A_L)    ? m_l : 32'hDEAD_BEEF;
    assign bif1.sdata_rd = 32'h5A5A_5A5F;

    logic [31:0] e_w;
    logic [23:0] e_l;
    logic [1:0]  e_st;
    logic        e_to;
    int          e_lat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected access list and response, derived from the job description only.
    task automatic model(input logic [23:0] a1, input logic [23:0] a2, input int nbusy,
                         input logic [1:0] fin, input logic [31:0] w, input logic [31:0] l,
                         input int limit);
        acc_t e;
        int polls;
        logic [1:0] st;
        bit done;
        exp_q.delete();
        e.cyc = 0;
        e.wr = 1'b1; e.addr = A_A1;   e.data = {8'h00, a1};  exp_q.push_back(e);
        e.wr = 1'b1; e.addr = A_A2;   e.data = {8'h00, a2};  exp_q.push_back(e);
        e.wr = 1'b1; e.addr = A_CTRL; e.data = 32'h1;        exp_q.push_back(e);
        e.wr = 1'b0; e.data = '0;
        polls = 0;
        done = 1'b0;
        while (!done) begin
            st = (polls < nbusy) ? 2'b11 : fin;
            e.addr = A_CTRL; exp_q.push_back(e);
            polls++;
            if (st != 2'b11) begin
                e.addr = A_W; exp_q.push_back(e);
                e.addr = A_L; exp_q.push_back(e);
                e_w = w; e_l = l[23:0]; e_st = st; e_to = 1'b0;
                done = 1'b1;
            end else if (polls >= limit) begin
                e_w = '0; e_l = '0; e_st = 2'b11; e_to = 1'b1;
                done = 1'b1;
            end
        end
        e_lat = exp_q.size() * (SC + 2) + (polls - 1) * GAP + 1;
    endtask

    // Bus monitor for instance 0: logs accesses and checks the access shape.
    logic        p_rd0 = 1'b0, p_wr0 = 1'b0;
    logic [15:0] p_addr0 = '0, a_addr0 = '0;
    int          slen0 = 0;
    acc_t        mon_e;
    always @(negedge clk) begin
        if (!n_reset) begin
            slen0 = 0;
        end else if ((bif0.srd || bif0.swr) && !(p_rd0 || p_wr0)) begin
            chk("strobe_overlap", 64'(bif0.srd & bif0.swr), 64'd0);
            chk("setup_addr", 64'(bif0.saddress), 64'(p_addr0));
            mon_e.wr   = bif0.swr;
            mon_e.addr = bif0.saddress;
            mon_e.data = bif0.swr ? bif0.sdata_wr : bif0.sdata_rd;
            mon_e.cyc  = cyc;
            log0.push_back(mon_e);
            a_addr0 = bif0.saddress;
            slen0 = 1;
        end else if (bif0.srd || bif0.swr) begin
            chk("strobe_overlap", 64'(bif0.srd & bif0.swr), 64'd0);
            chk("strobe_addr", 64'(bif0.saddress), 64'(a_addr0));
            slen0++;
        end else if (p_rd0 || p_wr0) begin
            chk("strobe_len", 64'(slen0), 64'(SC));
            chk("hold_addr", 64'(bif0.saddress), 64'(a_addr0));
            if (p_rd0 && a_addr0 == A_CTRL) polls0++;
        end
        p_rd0   = bif0.srd;
        p_wr0   = bif0.swr;
        p_addr0 = bif0.saddress;
    end

    // Instance 1 monitor: count status reads and any other reads.
    int   polls1 = 0, wl1 = 0;
    logic p_rd1 = 1'b0;
    always @(negedge clk) begin
        if (n_reset && bif1.srd && !p_rd1) begin
            if (bif1.saddress == A_CTRL) polls1++;
            else wl1++;
        end
        p_rd1 = bif1.srd;
    end

    task automatic run_job0(input logic [23:0] a1, input logic [23:0] a2, input int nbusy,
                            input logic [1:0] fin, input logic [31:0] w, input logic [31:0] l,
                            input int hold, input bit keep_req,
                            input logic [31:0] xw, input logic [23:0] xl, input logic [1:0] xst,
                            input logic xto, input int xlat);
        int n;
        bit got;
        int last;
        model(a1, a2, nbusy, fin, w, l, 1024);
        m_busy = nbusy; m_fin = fin; m_w = w; m_l = l; m_junk = $urandom;
        polls0 = 0;
        log0.delete();
        @(negedge clk);
        bif0.req_a1 = a1; bif0.req_a2 = a2; bif0.req_valid = 1'b1;
        @(posedge clk); #1;
        if (keep_req) begin
            bif0.req_a1 = 24'($urandom);
            bif0.req_a2 = 24'($urandom);
        end else begin
            bif0.req_valid = 1'b0;
        end
        n = 0; got = 1'b0;
        while (!got && n < 4000) begin
            @(negedge clk);
            n++;
            got = bif0.rsp_valid;
        end
        if (!got) begin
            chk("rsp_valid_wait", 64'd0, 64'd1);
            bif0.req_valid = 1'b0;
            return;
        end
        chk("latency", 64'(n), 64'(xlat));
        for (int k = 0; k <= hold; k++) begin
            if (k > 0) @(negedge clk);
            chk("rsp_valid", 64'(bif0.rsp_valid), 64'd1);
            chk("rsp_w", 64'(bif0.rsp_w), 64'(xw));
            chk("rsp_l", 64'(bif0.rsp_l), 64'(xl));
            chk("rsp_status", 64'(bif0.rsp_status), 64'(xst));
            chk("rsp_timeout", 64'(bif0.rsp_timeout), 64'(xto));
            chk("resp_req_ready", 64'(bif0.req_ready), 64'd0);
            chk("resp_bus_idle", 64'(bif0.srd | bif0.swr), 64'd0);
        end
        bif0.rsp_ready = 1'b1;
        @(negedge clk);
        bif0.rsp_ready = 1'b0;
        chk("after_rsp_valid", 64'(bif0.rsp_valid), 64'd0);
        chk("after_busy", 64'(bif0.busy), 64'd0);
        chk("after_req_ready", 64'(bif0.req_ready), 64'd1);
        bif0.req_valid = 1'b0;
        chk("access_count", 64'(log0.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log0.size(); i++) begin
            chk("acc_addr", 64'(log0[i].addr), 64'(exp_q[i].addr));
            chk("acc_dir", 64'(log0[i].wr), 64'(exp_q[i].wr));
            if (exp_q[i].wr) chk("acc_wdata", 64'(log0[i].data), 64'(exp_q[i].data));
        end
        last = -1;
        for (int i = 0; i < log0.size(); i++) begin
            if (!log0[i].wr && log0[i].addr == A_CTRL) begin
                if (last >= 0) chk("poll_spacing", 64'(log0[i].cyc - last), 64'(SC + 2 + GAP));
                last = log0[i].cyc;
            end
        end
    endtask

    task automatic run_timeout(input logic [23:0] a1, input logic [23:0] a2);
        int n;
        bit got;
        polls1 = 0; wl1 = 0;
        @(negedge clk);
        bif1.req_a1 = a1; bif1.req_a2 = a2; bif1.req_valid = 1'b1;
        @(posedge clk); #1;
        bif1.req_valid = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 4000) begin
            @(negedge clk);
            n++;
            got = bif1.rsp_valid;
        end
        if (!got) begin
            chk("to_rsp_valid_wait", 64'd0, 64'd1);
            return;
        end
        chk("to_latency", 64'(n), 64'd33);
        chk("to_timeout", 64'(bif1.rsp_timeout), 64'd1);
        chk("to_rsp_w", 64'(bif1.rsp_w), 64'd0);
        chk("to_rsp_l", 64'(bif1.rsp_l), 64'd0);
        chk("to_status", 64'(bif1.rsp_status), 64'd3);
        chk("to_polls", 64'(polls1), 64'd3);
        chk("to_wl_reads", 64'(wl1), 64'd0);
        bif1.rsp_ready = 1'b1;
        @(negedge clk);
        bif1.rsp_ready = 1'b0;
        chk("to_after_valid", 64'(bif1.rsp_valid), 64'd0);
        chk("to_after_ready", 64'(bif1.req_ready), 64'd1);
    endtask

    typedef struct {
        logic [23:0] a1, a2;
        int          nbusy;
        logic [1:0]  fin;
        logic [31:0] w, l;
        int          hold;
        bit          keep;
        logic [31:0] x_w;
        logic [23:0] x_l;
        logic [1:0]  x_st;
        int          x_lat;
    } vec_t;

    vec_t tbl[3];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [23:0] ra1, ra2;
        logic [31:0] rw, rl;
        logic [1:0]  rfin;
        int rbusy, rhold;
        bit rkeep;

        tbl[0] = '{24'd5, 24'd3, 0, 2'b00, 32'h28, 32'h2, 0, 1'b0, 32'h28, 24'h2, 2'b00, 25};
        tbl[1] = '{24'h00_1234, 24'h00_0042, 3, 2'b01, 32'hCAFE_0001, 32'h0000_0010, 1, 1'b0,
                   32'hCAFE_0001, 24'h10, 2'b01, 49};
        tbl[2] = '{24'hFF_FFFF, 24'h80_0001, 1, 2'b10, 32'hFFFF_FFFF, 32'hAB00_0007, 7, 1'b1,
                   32'hFFFF_FFFF, 24'h7, 2'b10, 33};

        n_reset = 1'b0;
        bif0.req_valid = 1'b0; bif0.req_a1 = '0; bif0.req_a2 = '0; bif0.rsp_ready = 1'b0;
        bif1.req_valid = 1'b0; bif1.req_a1 = '0; bif1.req_a2 = '0; bif1.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 n_reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_strobes", 64'({bif0.srd, bif0.swr}), 64'd0);
            chk("rst_req_ready", 64'(bif0.req_ready), 64'd1);
            chk("rst_busy", 64'(bif0.busy), 64'd0);
            chk("rst_rsp_valid", 64'(bif0.rsp_valid), 64'd0);
            chk("rst_saddress", 64'(bif0.saddress), 64'd0);
        end

        for (int i = 0; i < 3; i++)
            run_job0(tbl[i].a1, tbl[i].a2, tbl[i].nbusy, tbl[i].fin, tbl[i].w, tbl[i].l,
                     tbl[i].hold, tbl[i].keep, tbl[i].x_w, tbl[i].x_l, tbl[i].x_st, 1'b0, tbl[i].x_lat);

        run_timeout(24'h00_0ABC, 24'h00_0DEF);

        for (int i = 0; i < 16; i++) begin
            ra1 = 24'($urandom); ra2 = 24'($urandom);
            rbusy = int'($urandom_range(0, 4));
            rfin = 2'($urandom_range(0, 2));
            rw = $urandom; rl = $urandom;
            rhold = int'($urandom_range(0, 3));
            rkeep = 1'($urandom_range(0, 1));
            model(ra1, ra2, rbusy, rfin, rw, rl, 1024);
            run_job0(ra1, ra2, rbusy, rfin, rw, rl, rhold, rkeep, e_w, e_l, e_st, e_to, e_lat);
        end

        // Reset during the write strobe of the second argument.
        m_busy = 0; m_fin = 2'b00; polls0 = 0;
        @(negedge clk);
        bif0.req_a1 = 24'h111111; bif0.req_a2 = 24'h222222; bif0.req_valid = 1'b1;
        @(posedge clk); #1;
        bif0.req_valid = 1'b0;
        n = 0;
        while (!(bif0.swr && bif0.saddress == A_A2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_wr_a2", 64'(bif0.swr && bif0.saddress == A_A2), 64'd1);
        #2 n_reset = 1'b0;
        #1;
        chk("mid_rst_swr", 64'(bif0.swr), 64'd0);
        chk("mid_rst_srd", 64'(bif0.srd), 64'd0);
        chk("mid_rst_saddress", 64'(bif0.saddress), 64'd0);
        chk("mid_rst_sdata_wr", 64'(bif0.sdata_wr), 64'd0);
        chk("mid_rst_busy", 64'(bif0.busy), 64'd0);
        chk("mid_rst_req_ready", 64'(bif0.req_ready), 64'd1);
        chk("mid_rst_rsp", 64'({bif0.rsp_valid, bif0.rsp_timeout, bif0.rsp_status}), 64'd0);
        @(negedge clk);
        @(posedge clk); #2 n_reset = 1'b1;
        run_job0(24'h00_0777, 24'h00_0999, 2, 2'b01, 32'h0BAD_F00D, 32'h00FF_FFFF, 2, 1'b0,
                 32'h0BAD_F00D, 24'hFF_FFFF, 2'b01, 1'b0, 41);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
